// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ToyRISC definitions: datapath widths, ALU function encoding
// and the issue controller state type.
package toyrisc_pkg;

    localparam int WIDTH  = 32;
    localparam int DEST_W = 4;

    // func[3] picks the ALU half; func[2:0] picks the op within that half
    localparam int       FUNC_LOGIC_BIT = 3;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } issue_state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-facing and response channels of the ToyRISC issue controller.
interface alu_issue_ctrl_if
    import toyrisc_pkg::*;
#(
    parameter int WIDTH  = toyrisc_pkg::WIDTH,
    parameter int DEST_W = toyrisc_pkg::DEST_W
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_func;
    logic [WIDTH-1:0]  req_left;
    logic [WIDTH-1:0]  req_right;
    logic [DEST_W-1:0] req_dest;

    logic [WIDTH-1:0]  alu_left;
    logic [WIDTH-1:0]  alu_right;
    logic [3:0]        alu_func;
    logic [WIDTH-1:0]  alu_out;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_data;
    logic [DEST_W-1:0] rsp_dest;
    logic              rsp_zero;
    logic              busy;

    // The issue controller itself
    modport master (
        input  req_valid, req_func, req_left, req_right, req_dest, alu_out, rsp_ready,
        output req_ready, alu_left, alu_right, alu_func,
               rsp_valid, rsp_data, rsp_dest, rsp_zero, busy
    );

    // Decode stage, ALU and writeback around it
    modport slave (
        output req_valid, req_func, req_left, req_right, req_dest, alu_out, rsp_ready,
        input  req_ready, alu_left, alu_right, alu_func,
               rsp_valid, rsp_data, rsp_dest, rsp_zero, busy
    );

endinterface

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: takes one op, drives the external ALU,
// waits its fixed latency and hands the captured result to writeback.
module alu_issue_ctrl
    import toyrisc_pkg::*;
#(
    parameter int ALU_LATENCY = 1
) (
    input  logic           clock,
    input  logic           reset,
    alu_issue_ctrl_if.master bus
);

    issue_state_t      r_state;
    logic [2:0]        r_cnt;
    logic              r_reqReady;
    logic [WIDTH-1:0]  r_aluLeft;
    logic [WIDTH-1:0]  r_aluRight;
    logic [3:0]        r_aluFunc;
    logic [WIDTH-1:0]  r_rspData;
    logic [DEST_W-1:0] r_rspDest;
    logic              r_rspZero;
    logic              r_rspValid;
    logic              r_busy;

    localparam logic [2:0] LAT_LOAD = 3'(ALU_LATENCY);

    // Only one op is ever in flight, so the destination index can be
    // latched straight into the response register at acceptance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_reqReady <= 1'b0;
            r_aluLeft  <= '0;
            r_aluRight <= '0;
            r_aluFunc  <= '0;
            r_rspData  <= '0;
            r_rspDest  <= '0;
            r_rspZero  <= 1'b0;
            r_rspValid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_reqReady <= 1'b1;
                    if (bus.req_valid && r_reqReady) begin
                        r_aluLeft  <= bus.req_left;
                        r_aluRight <= bus.req_right;
                        r_aluFunc  <= bus.req_func;
                        r_rspDest  <= bus.req_dest;
                        r_cnt      <= LAT_LOAD;
                        r_reqReady <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        r_rspData  <= bus.alu_out;
                        r_rspZero  <= (bus.alu_out == '0);
                        r_rspValid <= 1'b1;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_reqReady <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_reqReady;
    assign bus.alu_left  = r_aluLeft;
    assign bus.alu_right = r_aluRight;
    assign bus.alu_func  = r_aluFunc;
    assign bus.rsp_valid = r_rspValid;
    assign bus.rsp_data  = r_rspData;
    assign bus.rsp_dest  = r_rspDest;
    assign bus.rsp_zero  = r_rspZero;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: three instances (ALU latency 0, 1, 7)
// share one stimulus, each paired with a behavioural ALU of matching latency.
module tb_alu_issue_ctrl;
    import toyrisc_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        reqValid = 1'b0;
    logic [3:0]  reqFunc = '0;
    logic [31:0] reqLeft = '0;
    logic [31:0] reqRight = '0;
    logic [3:0]  reqDest = '0;
    logic        rspReady = 1'b0;

    int sel = 1;
    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    alu_issue_ctrl_if if0 ();
    alu_issue_ctrl_if if1 ();
    alu_issue_ctrl_if if7 ();

    alu_issue_ctrl #(.ALU_LATENCY(0)) dut0 (.clock(clock), .reset(reset), .bus(if0.master));
    alu_issue_ctrl #(.ALU_LATENCY(1)) dut1 (.clock(clock), .reset(reset), .bus(if1.master));
    alu_issue_ctrl #(.ALU_LATENCY(7)) dut7 (.clock(clock), .reset(reset), .bus(if7.master));

    always #5 clock = ~clock;

    // Stimulus fans out to every instance
    assign if0.req_valid = reqValid;  assign if1.req_valid = reqValid;  assign if7.req_valid = reqValid;
    assign if0.req_func  = reqFunc;   assign if1.req_func  = reqFunc;   assign if7.req_func  = reqFunc;
    assign if0.req_left  = reqLeft;   assign if1.req_left  = reqLeft;   assign if7.req_left  = reqLeft;
    assign if0.req_right = reqRight;  assign if1.req_right = reqRight;  assign if7.req_right = reqRight;
    assign if0.req_dest  = reqDest;   assign if1.req_dest  = reqDest;   assign if7.req_dest  = reqDest;
    assign if0.rsp_ready = rspReady;  assign if1.rsp_ready = rspReady;  assign if7.rsp_ready = rspReady;

    function automatic logic [31:0] aluFn(logic [3:0] f, logic [31:0] l, logic [31:0] r);
        logic [31:0] res;
        if (f[FUNC_LOGIC_BIT]) begin
            case (f[2:0])
                OP_OR:   res = l | r;
                OP_XOR:  res = l ^ r;
                default: res = l & r;
            endcase
        end else begin
            case (f[2:0])
                OP_SUB:  res = l - r;
                default: res = l + r;
            endcase
        end
        return res;
    endfunction

    // Behavioural ALUs: combinational, one stage and seven stages deep
    logic [31:0] alu1;
    logic [31:0] pipe7 [7];
    initial begin
        alu1 = '0;
        for (int k = 0; k < 7; k++) pipe7[k] = '0;
    end
    assign if0.alu_out = aluFn(if0.alu_func, if0.alu_left, if0.alu_right);
    always @(posedge clock) alu1 <= aluFn(if1.alu_func, if1.alu_left, if1.alu_right);
    assign if1.alu_out = alu1;
    always @(posedge clock) begin
        pipe7[0] <= aluFn(if7.alu_func, if7.alu_left, if7.alu_right);
        for (int k = 1; k < 7; k++) pipe7[k] <= pipe7[k-1];
    end
    assign if7.alu_out = pipe7[6];

    logic        obsReqReady, obsRspValid, obsRspZero, obsBusy;
    logic [31:0] obsRspData, obsAluLeft;
    logic [3:0]  obsRspDest;
    always_comb begin
        obsReqReady = if1.req_ready; obsRspValid = if1.rsp_valid; obsRspZero = if1.rsp_zero;
        obsBusy = if1.busy; obsRspData = if1.rsp_data; obsAluLeft = if1.alu_left; obsRspDest = if1.rsp_dest;
        if (sel == 0) begin
            obsReqReady = if0.req_ready; obsRspValid = if0.rsp_valid; obsRspZero = if0.rsp_zero;
            obsBusy = if0.busy; obsRspData = if0.rsp_data; obsAluLeft = if0.alu_left; obsRspDest = if0.rsp_dest;
        end else if (sel == 2) begin
            obsReqReady = if7.req_ready; obsRspValid = if7.rsp_valid; obsRspZero = if7.rsp_zero;
            obsBusy = if7.busy; obsRspData = if7.rsp_data; obsAluLeft = if7.alu_left; obsRspDest = if7.rsp_dest;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Reset all instances and let the latency-7 ALU pipeline flush to zero
    task automatic doReset();
        reqValid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) tick();
    endtask

    task automatic applyStimulus(input logic [3:0] f, input logic [31:0] l, input logic [31:0] r, input logic [3:0] d);
        reqFunc = f; reqLeft = l; reqRight = r; reqDest = d;
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
    endtask

    task automatic waitResponse(output int n);
        n = 0;
        while (!obsRspValid && n < 20) begin
            tick();
            n++;
        end
    endtask

    int lat;
    int acceptCyc [4];
    logic [3:0]  vFunc [4] = '{4'h0, 4'h1, 4'h8, 4'h9};
    logic [31:0] vLeft [4] = '{32'd1, 32'd10, 32'hFF, 32'hF0};
    logic [31:0] vRight[4] = '{32'd2, 32'd3, 32'h0F, 32'h0F};
    logic [3:0]  vDest [4] = '{4'd5, 4'd6, 4'd7, 4'd8};
    logic [31:0] vRes  [4] = '{32'd3, 32'd7, 32'h0F, 32'hFF};

    initial begin
        // Reset values while reset is held
        sel = 1;
        #2;
        checkOutput("rst_req_ready", 32'(obsReqReady), 32'd0);
        checkOutput("rst_rsp_valid", 32'(obsRspValid), 32'd0);
        checkOutput("rst_busy", 32'(obsBusy), 32'd0);
        checkOutput("rst_alu_left", obsAluLeft, 32'd0);
        checkOutput("rst_rsp_data", obsRspData, 32'd0);
        doReset();
        checkOutput("post_rst_req_ready", 32'(obsReqReady), 32'd1);

        // Basic latency, ALU_LATENCY=1: 5+7 -> 12 to r3
        applyStimulus(4'h0, 32'd5, 32'd7, 4'd3);
        checkOutput("basic_busy", 32'(obsBusy), 32'd1);
        checkOutput("basic_req_ready", 32'(obsReqReady), 32'd0);
        checkOutput("basic_alu_left", obsAluLeft, 32'd5);
        waitResponse(lat);
        checkOutput("basic_latency", 32'(lat), 32'd2);
        checkOutput("basic_data", obsRspData, 32'd12);
        checkOutput("basic_dest", 32'(obsRspDest), 32'd3);
        checkOutput("basic_zero", 32'(obsRspZero), 32'd0);
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        checkOutput("basic_hs_valid", 32'(obsRspValid), 32'd0);
        checkOutput("basic_hs_req_ready", 32'(obsReqReady), 32'd1);

        // Zero result: 9-9 to r9
        applyStimulus(4'h1, 32'd9, 32'd9, 4'd9);
        waitResponse(lat);
        checkOutput("zero_latency", 32'(lat), 32'd2);
        checkOutput("zero_data", obsRspData, 32'd0);
        checkOutput("zero_flag", 32'(obsRspZero), 32'd1);

        // Backpressure with a competing request that must be ignored
        reqFunc = 4'h0; reqLeft = 32'h55; reqRight = 32'h1; reqDest = 4'd2;
        reqValid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput("bp_valid", 32'(obsRspValid), 32'd1);
            checkOutput("bp_data", obsRspData, 32'd0);
            checkOutput("bp_dest", 32'(obsRspDest), 32'd9);
            checkOutput("bp_zero", 32'(obsRspZero), 32'd1);
            checkOutput("bp_req_ready", 32'(obsReqReady), 32'd0);
        end
        reqValid = 1'b0;
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        checkOutput("bp_hs_valid", 32'(obsRspValid), 32'd0);
        checkOutput("bp_hs_req_ready", 32'(obsReqReady), 32'd1);
        checkOutput("bp_alu_left_kept", obsAluLeft, 32'd9);

        // Latency sweep: combinational ALU
        doReset();
        sel = 0;
        applyStimulus(4'h0, 32'd100, 32'd23, 4'd1);
        waitResponse(lat);
        checkOutput("lat0_latency", 32'(lat), 32'd1);
        checkOutput("lat0_data", obsRspData, 32'd123);

        // Latency sweep: seven-stage ALU, xor
        doReset();
        sel = 2;
        applyStimulus(4'hA, 32'h0000F0F0, 32'h00000FF0, 4'd4);
        waitResponse(lat);
        checkOutput("lat7_latency", 32'(lat), 32'd8);
        checkOutput("lat7_data", obsRspData, 32'h0000FF00);
        checkOutput("lat7_dest", 32'(obsRspDest), 32'd4);

        // Reset one cycle after acceptance abandons the op
        doReset();
        sel = 2;
        applyStimulus(4'h0, 32'd40, 32'd2, 4'd11);
        tick();
        reset = 1'b1;
        #1;
        checkOutput("midrst_valid", 32'(obsRspValid), 32'd0);
        checkOutput("midrst_busy", 32'(obsBusy), 32'd0);
        checkOutput("midrst_alu_left", obsAluLeft, 32'd0);
        checkOutput("midrst_dest", 32'(obsRspDest), 32'd0);
        checkOutput("midrst_req_ready", 32'(obsReqReady), 32'd0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        checkOutput("midrst_no_rsp", 32'(obsRspValid), 32'd0);
        checkOutput("midrst_ready_again", 32'(obsReqReady), 32'd1);
        applyStimulus(4'h9, 32'h0F00, 32'h00F0, 4'd12);
        waitResponse(lat);
        checkOutput("midrst_next_latency", 32'(lat), 32'd8);
        checkOutput("midrst_next_data", obsRspData, 32'h0FF0);

        // Back-to-back with rsp_ready tied high, ALU_LATENCY=1
        doReset();
        sel = 1;
        rspReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            reqFunc = vFunc[i]; reqLeft = vLeft[i]; reqRight = vRight[i]; reqDest = vDest[i];
            reqValid = 1'b1;
            for (int w = 0; w < 10 && !obsReqReady; w++) tick();
            tick();
            acceptCyc[i] = cyc;
            reqValid = 1'b0;
            waitResponse(lat);
            checkOutput($sformatf("b2b%0d_latency", i), 32'(lat), 32'd2);
            checkOutput($sformatf("b2b%0d_data", i), obsRspData, vRes[i]);
            checkOutput($sformatf("b2b%0d_dest", i), 32'(obsRspDest), 32'(vDest[i]));
            if (i > 0) checkOutput($sformatf("b2b%0d_spacing", i), 32'(acceptCyc[i] - acceptCyc[i-1]), 32'd4);
        end
        rspReady = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Execute-stage issue controller for ToyRISC: the requester side of the ALU interface. It accepts one operation at a time over a valid/ready request channel and drives registered operands and `func` to the ALU. It waits the ALU's fixed latency, captures the result with its destination register index and a zero flag, and presents it on a valid/ready response channel toward writeback. The ALU is instantiated beside this block in the datapath top, not inside it.

## Interface
- `WIDTH`, 32: operand and result width.
- `DEST_W`, 4: destination register index width.
- `ALU_LATENCY`, 1: clock edges from operand presentation until `alu_out` is valid (0 = combinational). Legal range 0..7.
- `clock` in 1: single clock; all state is updated on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_func` in 4: ALU function. Bit 3 = 0 selects arithmetic, bit 3 = 1 selects logic.
- `req_left` in WIDTH: left operand.
- `req_right` in WIDTH: right operand.
- `req_dest` in DEST_W: destination register index.
- `alu_left` out WIDTH: registered left operand to the ALU.
- `alu_right` out WIDTH: registered right operand to the ALU.
- `alu_func` out 4: registered function to the ALU.
- `alu_out` in WIDTH: ALU result.
- `rsp_valid` out 1: result present.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_data` out WIDTH: captured result.
- `rsp_dest` out DEST_W: destination index of the result.
- `rsp_zero` out 1: 1 when `rsp_data` == 0.
- `busy` out 1: high in EXEC or HOLD.

## Operation
- FSM states: IDLE, EXEC, HOLD. Reset forces IDLE.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, at the edge: latch `req_left`, `req_right` and `req_func` into `alu_left`, `alu_right` and `alu_func`; latch `req_dest`; load `cnt` with ALU_LATENCY; go to EXEC.
- EXEC:
  - `req_ready` = 0.
  - If `cnt` != 0, decrement `cnt`.
  - If `cnt` == 0: capture `alu_out` into `rsp_data`, set `rsp_zero` = (`alu_out` == 0), set `rsp_valid` = 1, go to HOLD.
- HOLD:
  - `req_ready` = 0.
  - `rsp_valid` = 1; `rsp_data`, `rsp_dest` and `rsp_zero` are held stable until `rsp_ready`.
  - On `rsp_ready` at the edge: clear `rsp_valid`, go to IDLE.
- `alu_*` outputs hold their last value in IDLE. They change only on request acceptance.
- `req_valid` in any state other than IDLE is ignored. The requester must hold the request until it sees `req_ready`.
- `cnt` is a 3-bit down-counter and never wraps: the decrement is suppressed at 0.
- `req_func` is passed through unmodified; the block does not decode it.

## Timing
- Reset values:
  - State IDLE; `cnt`, `alu_left`, `alu_right`, `alu_func`, `rsp_data`, `rsp_dest`, `rsp_zero`, `rsp_valid` and `busy` all 0.
  - `req_ready` = 0 while `reset` is asserted, then 1 from the first cycle after deassertion.
- Acceptance at edge E0. `rsp_valid` rises after edge E0+ALU_LATENCY+1, so request-to-response latency is ALU_LATENCY+1 cycles.
- `rsp_ready` already high when `rsp_valid` rises: the handshake completes at the next edge, and `req_ready` returns 1 in the following cycle.
- Best-case throughput is one operation per ALU_LATENCY+3 cycles. Requests do not overlap.
- Reset mid-operation (EXEC or HOLD): the operation is abandoned and no response is produced. `rsp_valid` drops asynchronously.
- `rsp_ready` held low: the block stays in HOLD indefinitely with outputs stable.

## Structure
- Shared `toyrisc_pkg` holds:
  - `WIDTH` and `DEST_W` defaults;
  - the func encoding constants (arith/logic select bit, 3-bit op codes);
  - the `issue_state_t` enum {IDLE, EXEC, HOLD}.
- No sub-module: the FSM, counter and capture registers form a single module.
- The datapath top wires `alu_*` and `alu_out` to `alu`.

## Test plan
- Basic latency: ALU_LATENCY=1 with an ALU model; func=4'h0, left=5, right=7, dest=3, model returns 12 -> `rsp_valid` 2 cycles after acceptance with `rsp_data`=12, `rsp_dest`=3, `rsp_zero`=0.
- Zero result: left=9, right=9, model returns 0 -> `rsp_zero`=1, `rsp_data`=0.
- Backpressure: hold `rsp_ready`=0 for 10 cycles -> `rsp_*` stable, `req_ready`=0, and a new `req_valid` is ignored. Raise `rsp_ready` -> one handshake, then `req_ready`=1 in the next cycle.
- Latency sweep: ALU_LATENCY=0 -> response 1 cycle after acceptance; ALU_LATENCY=7 -> 8 cycles; the result is captured exactly at `cnt`==0.
- Reset mid-EXEC: assert `reset` one cycle after acceptance -> `rsp_valid` stays 0, all outputs return to reset values, and the next request completes normally.
- Back-to-back: 4 requests with `rsp_ready` tied high and ALU_LATENCY=1 -> accepted every 4 cycles, responses in order with correct `dest` values.
